// File: rtl/except_arbiter.sv
// mem_pt2 stage register: picks one exception per instruction by fixed priority
// and registers it toward cp0, with an interrupt hold-off window after each exception.
module except_arbiter #(
   parameter int HOLDOFF = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        valid_i,
   input  logic [31:0] pc_i,
   input  logic        delay_slot_i,
   input  logic [31:0] mem_addr_i,
   input  logic [7:0]  exc_flags_i,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   output logic [31:0] except_type_cp0,
   output logic        delay_slot_cp0,
   output logic [31:0] pc_mempt2,
   output logic [31:0] mem_addr_ex,
   output logic        valid_o,
   output logic        int_pend_o
);

   localparam logic [31:0] CODE_NONE   = 32'h0;
   localparam logic [31:0] CODE_INT    = 32'h1;
   localparam logic [31:0] CODE_ADEL   = 32'h4;
   localparam logic [31:0] CODE_ADES   = 32'h5;
   localparam logic [31:0] CODE_SYS    = 32'h8;
   localparam logic [31:0] CODE_BREAK  = 32'h9;
   localparam logic [31:0] CODE_RI     = 32'ha;
   localparam logic [31:0] CODE_OVFL   = 32'hc;
   localparam logic [31:0] CODE_ERET   = 32'he;
   localparam logic [31:0] CODE_WRPC   = 32'h10;

   logic [1:0]  hold_cnt;
   logic        int_pend;
   logic        int_cond;
   logic        int_req;
   logic        load;
   logic        issue_int;
   logic [31:0] sel_code;
   logic [31:0] sel_addr;

   always_comb begin
      int_cond  = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause[15:8] & cp0_status[15:8]));
      int_req   = int_pend | (int_cond & (hold_cnt == 2'd0));
      load      = ~flush & ~stall;
      issue_int = load & valid_i & int_req;
   end

   always_comb begin
      sel_code = CODE_NONE;
      sel_addr = mem_addr_i;
      if (valid_i) begin
         if (int_req)             sel_code = CODE_INT;
         else if (exc_flags_i[0]) begin
            sel_code = CODE_WRPC;
            sel_addr = pc_i;  // bad fetch address is the PC itself
         end
         else if (exc_flags_i[1]) sel_code = CODE_RI;
         else if (exc_flags_i[2]) sel_code = CODE_OVFL;
         else if (exc_flags_i[3]) sel_code = CODE_SYS;
         else if (exc_flags_i[4]) sel_code = CODE_BREAK;
         else if (exc_flags_i[5]) sel_code = CODE_ERET;
         else if (exc_flags_i[6]) sel_code = CODE_ADEL;
         else if (exc_flags_i[7]) sel_code = CODE_ADES;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         except_type_cp0 <= '0;
         delay_slot_cp0  <= 1'b0;
         pc_mempt2       <= '0;
         mem_addr_ex     <= '0;
         valid_o         <= 1'b0;
         hold_cnt        <= 2'd0;
         int_pend        <= 1'b0;
      end else begin
         if (flush) begin
            except_type_cp0 <= '0;
            delay_slot_cp0  <= 1'b0;
            pc_mempt2       <= '0;
            mem_addr_ex     <= '0;
            valid_o         <= 1'b0;
         end else if (!stall) begin
            except_type_cp0 <= sel_code;
            delay_slot_cp0  <= delay_slot_i;
            pc_mempt2       <= pc_i;
            mem_addr_ex     <= sel_addr;
            valid_o         <= valid_i;
         end

         // cp0 sets Status.EXL one edge late, so mask interrupts until it has
         if (load && sel_code != CODE_NONE)
            hold_cnt <= (sel_code == CODE_ERET) ? 2'd1 : 2'(HOLDOFF);
         else if (hold_cnt != 2'd0)
            hold_cnt <= hold_cnt - 2'd1;

         if (!int_cond || issue_int)
            int_pend <= 1'b0;
         else if (hold_cnt == 2'd0)
            int_pend <= 1'b1;
      end
   end

   assign int_pend_o = int_pend;

endmodule

// File: tb/tb_except_arbiter.sv
// Directed and randomized bench for except_arbiter against a cycle-level reference model.
module tb_except_arbiter;

   localparam int HOLDOFF = 1;

   logic        clk = 1'b0;
   logic        rst, stall, flush, valid_i, delay_slot_i;
   logic [31:0] pc_i, mem_addr_i, cp0_status, cp0_cause;
   logic [7:0]  exc_flags_i;
   logic [31:0] except_type_cp0, pc_mempt2, mem_addr_ex;
   logic        delay_slot_cp0, valid_o, int_pend_o;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_code, m_pc, m_addr;
   logic        m_ds, m_valid, m_pend;
   int          m_hc;

   // exception codes in priority order of exc_flags_i bits 0..7
   logic [31:0] prio_code [8] = '{32'h10, 32'ha, 32'hc, 32'h8, 32'h9, 32'he, 32'h4, 32'h5};

   except_arbiter #(.HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_i(valid_i),
      .pc_i(pc_i), .delay_slot_i(delay_slot_i), .mem_addr_i(mem_addr_i),
      .exc_flags_i(exc_flags_i), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
      .except_type_cp0(except_type_cp0), .delay_slot_cp0(delay_slot_cp0),
      .pc_mempt2(pc_mempt2), .mem_addr_ex(mem_addr_ex), .valid_o(valid_o),
      .int_pend_o(int_pend_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [31:0] pc, input logic ds,
                         input logic [31:0] addr, input logic [7:0] fl);
      valid_i = v; pc_i = pc; delay_slot_i = ds; mem_addr_i = addr; exc_flags_i = fl;
   endtask

   // advance one clock: model predicts from the pre-edge inputs, then outputs are compared
   task automatic step();
      bit          cond, req, ld;
      logic [31:0] code, addr;
      cond = cp0_status[0] && !cp0_status[1] && ((cp0_cause[15:8] & cp0_status[15:8]) != 0);
      req  = m_pend || (cond && m_hc == 0);
      ld   = !flush && !stall;
      code = 32'h0;
      addr = mem_addr_i;
      if (valid_i) begin
         if (req) code = 32'h1;
         else begin
            for (int i = 7; i >= 0; i--)
               if (exc_flags_i[i]) code = prio_code[i];
            if (code == 32'h10) addr = pc_i;
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         m_code = 0; m_ds = 0; m_pc = 0; m_addr = 0; m_valid = 0; m_hc = 0; m_pend = 0;
      end else begin
         if (!cond || (ld && valid_i && req)) m_pend = 1'b0;
         else if (m_hc == 0)                  m_pend = 1'b1;
         if (ld && code != 0) m_hc = (code == 32'he) ? 1 : HOLDOFF;
         else if (m_hc > 0)   m_hc = m_hc - 1;
         if (flush) begin
            m_code = 0; m_ds = 0; m_pc = 0; m_addr = 0; m_valid = 0;
         end else if (!stall) begin
            m_code = code; m_ds = delay_slot_i; m_pc = pc_i; m_addr = addr; m_valid = valid_i;
         end
      end
      chk("code",  except_type_cp0, m_code);
      chk("ds",    {31'b0, delay_slot_cp0}, {31'b0, m_ds});
      chk("pc",    pc_mempt2, m_pc);
      chk("addr",  mem_addr_ex, m_addr);
      chk("valid", {31'b0, valid_o}, {31'b0, m_valid});
      chk("pend",  {31'b0, int_pend_o}, {31'b0, m_pend});
   endtask

   logic [31:0] s_code, s_pc, s_addr;

   initial begin
      m_code = 0; m_ds = 0; m_pc = 0; m_addr = 0; m_valid = 0; m_hc = 0; m_pend = 0;
      rst = 1; stall = 0; flush = 0; cp0_status = 0; cp0_cause = 0;
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
      step();
      chk("reset_code", except_type_cp0, 32'h0);
      chk("reset_valid", {31'b0, valid_o}, 32'h0);
      rst = 0;

      // ovfl and sys together: ovfl wins
      set_in(1'b1, 32'hbfc00100, 1'b0, 32'h0, 8'h0c);
      step();
      chk("ovfl_code", except_type_cp0, 32'hc);
      chk("ovfl_pc", pc_mempt2, 32'hbfc00100);
      chk("ovfl_valid", {31'b0, valid_o}, 32'h1);

      // fetch misalign in delay slot
      set_in(1'b1, 32'h80000002, 1'b1, 32'h1234, 8'h01);
      step();
      chk("wrpc_code", except_type_cp0, 32'h10);
      chk("wrpc_addr", mem_addr_ex, 32'h80000002);
      chk("wrpc_ds", {31'b0, delay_slot_cp0}, 32'h1);
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
      step();

      // interrupt pending across bubbles, taken on first valid instruction
      cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pend_bubble", {31'b0, int_pend_o}, 32'h1);
      end
      set_in(1'b1, 32'h80001000, 1'b0, 32'h0, 8'h0);
      step();
      chk("int_code", except_type_cp0, 32'h1);
      chk("int_pend_clr", {31'b0, int_pend_o}, 32'h0);
      set_in(1'b1, 32'h80001004, 1'b0, 32'h0, 8'h0);
      step();
      chk("holdoff_code", except_type_cp0, 32'h0);
      set_in(1'b1, 32'h80001008, 1'b0, 32'h0, 8'h0);
      step();
      chk("retake_code", except_type_cp0, 32'h1);
      cp0_status = 0; cp0_cause = 0;

      // stall holds outputs, then flush overrides stall
      set_in(1'b1, 32'h80002000, 1'b0, 32'h55aa, 8'h10);
      step();
      s_code = except_type_cp0; s_pc = pc_mempt2; s_addr = mem_addr_ex;
      chk("brk_code", s_code, 32'h9);
      stall = 1;
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, $urandom, 1'($urandom), $urandom, 8'($urandom));
         step();
         chk("stall_code", except_type_cp0, s_code);
         chk("stall_pc", pc_mempt2, s_pc);
         chk("stall_addr", mem_addr_ex, s_addr);
      end
      flush = 1;
      step();
      chk("flush_code", except_type_cp0, 32'h0);
      chk("flush_pc", pc_mempt2, 32'h0);
      chk("flush_valid", {31'b0, valid_o}, 32'h0);
      stall = 0; flush = 0;

      // load address error beats store address error; then reset clears
      set_in(1'b1, 32'h80003000, 1'b0, 32'h1003, 8'hc0);
      step();
      chk("adel_code", except_type_cp0, 32'h4);
      chk("adel_addr", mem_addr_ex, 32'h1003);
      rst = 1;
      step();
      chk("rst_code", except_type_cp0, 32'h0);
      chk("rst_addr", mem_addr_ex, 32'h0);
      chk("rst_pc", pc_mempt2, 32'h0);
      rst = 0;

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 63) == 0);
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 15) == 0);
         set_in(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), $urandom,
                8'($urandom) & 8'($urandom) & 8'($urandom));
         cp0_status = $urandom;
         cp0_status[0] = ($urandom_range(0, 3) != 0);
         cp0_status[1] = ($urandom_range(0, 3) == 0);
         cp0_cause = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
